entry_age_tracker: RTL and testbench
====================================

Name: entry_age_tracker

Overview:
Downstream consumer of the one-second tick timer. Tracks per-entry age, in seconds, for the associative buffer's ENTRIES slots and drives the timer's enable input. Reports entries whose age reaches MAX_AGE one at a time over a valid/ready handshake, and invalidates each entry when its report is accepted. The buffer controller touches entries on write/hit and clears them on explicit delete.

Parameters:
ENTRIES, 8, number of tracked entries (power of two, >=2)
IDX_W, 3, index width, log2(ENTRIES)
AGE_W, 4, age counter width
MAX_AGE, 10, age in seconds at which an entry expires (1..2^AGE_W-1)

Ports:
clk  in  1  system clock (50 MHz)
sync_reset  in  1  synchronous, active-high reset
second_elapsed  in  1  one-cycle tick from timer
timer_enabled  out  1  enable to timer; = OR of valid_vec
touch_valid  in  1  refresh/allocate entry touch_idx
touch_idx  in  IDX_W  entry to touch
clear_valid  in  1  delete entry clear_idx
clear_idx  in  IDX_W  entry to clear
valid_vec  out  ENTRIES  per-entry valid bits
expire_valid  out  1  expiry report pending
expire_idx  out  IDX_W  index of expiring entry
expire_ready  in  1  consumer accepts report

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (sync_reset). On a reset edge: all valid=0, all age=0, FSM=IDLE, ptr=0, expire_valid=0, expire_idx=0. timer_enabled=0 follows from valid_vec. Reset overrides all other inputs, including mid-handshake.
- Per entry i:
  - valid[i] and age[i] (AGE_W bits).
  - expired[i] = valid[i] && age[i]==MAX_AGE.
- Update priority per entry on each edge, highest first:
  1. clear (clear_valid && clear_idx==i): valid=0, age=0.
  2. touch: valid=1, age=0.
  3. Accepted expiry of i (see FSM): valid=0, age=0.
  4. tick (second_elapsed && valid[i]): age+1, saturating at MAX_AGE.
- Touch and clear on different indices in the same cycle both take effect.
- Tick is ignored for invalid entries. Saturation: no wrap past MAX_AGE.
- timer_enabled is combinational from the valid registers.
- FSM states: IDLE, SCAN, PRESENT. ptr is IDX_W bits and wraps ENTRIES-1 -> 0.
  - IDLE: if any expired[], go to SCAN next edge.
  - SCAN: if no expired[], go to IDLE. Else if expired[ptr], register expire_idx=ptr, set expire_valid=1, go to PRESENT. Else ptr=ptr+1. This scan gives round-robin fairness.
  - PRESENT: expire_valid and expire_idx held stable until expire_ready=1. On the handshake edge:
    - entry expire_idx is invalidated only if it is still expired and is not touched or cleared in that cycle;
    - expire_valid=0, ptr=ptr+1, go to SCAN.
  - A stale report (entry touched or cleared while presented) is still delivered and completes normally. The entry keeps its new state.
- Latency from expired[i] rising to expire_valid: 2 to ENTRIES+1 cycles. Back-to-back reports are separated by at least 1 cycle in SCAN.

Optional Feature:
Macro EXPIRE_COUNT_EN.
- Defined: adds output expire_count (16 bits). It increments on each handshake edge that actually invalidates an entry, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert sync_reset for 2 cycles during active traffic -> valid_vec=8'h00, expire_valid=0, timer_enabled=0 on the next edge.
- Basic expiry: touch idx 3, apply 10 ticks, hold expire_ready=1 -> expire_valid=1 with expire_idx=3 within 9 cycles of the 10th tick; after the handshake, valid_vec[3]=0, timer_enabled=0, expire_count=1.
- Refresh: touch idx 5, apply 9 ticks, touch idx 5, apply 9 ticks -> no expire_valid; 1 more tick -> expire_idx=5.
- Ordering and stability: touch idx 1 and idx 6 together, apply 10 ticks, hold expire_ready=0 for 20 cycles -> expire_idx=1 stable throughout; raise ready -> reports 1 then 6, valid_vec=8'h00.
- Priority: touch idx 2 and clear idx 2 in the same cycle -> valid_vec[2]=0. Touch idx 4, apply 15 ticks -> age saturates at 10 and exactly one report is issued.
- Stale report: idx 4 presented; touch idx 4 while expire_ready=0, then ready -> handshake completes, valid_vec[4]=1, expire_count unchanged, no re-report until 10 more ticks.

Source files
------------

// File: rtl/entry_age_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : entry_age_tracker
//  Purpose  : Per-entry age tracking (in seconds) for the associative buffer.
//             Entries are allocated/refreshed by touch and removed by clear.
//             Entries reaching MAX_AGE are reported one at a time over a
//             valid/ready handshake and invalidated when the report is taken.
//             The one-second timer runs only while at least one entry is valid.
//  Options  : `define EXPIRE_COUNT_EN adds a 16-bit saturating count of
//             entries actually invalidated by accepted expiry reports.
//  Revision : 1.0  initial release
// ============================================================================
module entry_age_tracker #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3,
    parameter int AGE_W   = 4,
    parameter int MAX_AGE = 10
) (
    input  logic               clk,
    input  logic               sync_reset,
    input  logic               second_elapsed,
    output logic               timer_enabled,
    input  logic               touch_valid,
    input  logic [IDX_W-1:0]   touch_idx,
    input  logic               clear_valid,
    input  logic [IDX_W-1:0]   clear_idx,
    output logic [ENTRIES-1:0] valid_vec,
    output logic               expire_valid,
    output logic [IDX_W-1:0]   expire_idx,
    input  logic               expire_ready
`ifdef EXPIRE_COUNT_EN
    ,
    output logic [15:0]        expire_count
`endif
);

    localparam logic [AGE_W-1:0] c_MAX_AGE = AGE_W'(MAX_AGE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    // Entry state
    logic [ENTRIES-1:0] r_valid;
    logic [AGE_W-1:0]   r_age [ENTRIES];

    // Reporter state
    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic               r_expire_valid;
    logic [IDX_W-1:0]   r_expire_idx;

    // Per-entry decode
    logic [ENTRIES-1:0] w_expired;
    logic [ENTRIES-1:0] w_clr_hit;
    logic [ENTRIES-1:0] w_tch_hit;
    logic [ENTRIES-1:0] w_acc_hit;
    logic               w_any_expired;
    logic               w_handshake;

    // A report is consumed on any edge where it is presented and ready is high.
    assign w_handshake   = (r_state == ST_PRESENT) && expire_ready;
    assign w_any_expired = |w_expired;

    // Decode which entries are expired, cleared, touched or accepted this cycle.
    // Accepted expiry only applies if the entry is still expired, so a stale
    // report (entry refreshed while presented) never knocks out a live entry.
    always_comb begin
        w_expired = '0;
        w_clr_hit = '0;
        w_tch_hit = '0;
        w_acc_hit = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_expired[i] = r_valid[i] && (r_age[i] == c_MAX_AGE);
            w_clr_hit[i] = clear_valid && (clear_idx == IDX_W'(i));
            w_tch_hit[i] = touch_valid && (touch_idx == IDX_W'(i));
            w_acc_hit[i] = w_handshake && (r_expire_idx == IDX_W'(i)) && w_expired[i];
        end
    end

    // Per-entry valid/age update: clear > touch > accepted expiry > tick.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (w_clr_hit[i]) begin
                    r_valid[i] <= 1'b0;
                    r_age[i]   <= '0;
                end else if (w_tch_hit[i]) begin
                    r_valid[i] <= 1'b1;
                    r_age[i]   <= '0;
                end else if (w_acc_hit[i]) begin
                    r_valid[i] <= 1'b0;
                    r_age[i]   <= '0;
                end else if (second_elapsed && r_valid[i] && (r_age[i] != c_MAX_AGE)) begin
                    // Saturate at MAX_AGE so an unserviced entry stays expired.
                    r_age[i] <= r_age[i] + AGE_W'(1);
                end
            end
        end
    end

    // Round-robin expiry reporter: scan from ptr, present one entry, resume
    // scanning just past the presented index so every entry gets a turn.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state        <= ST_IDLE;
            r_ptr          <= '0;
            r_expire_valid <= 1'b0;
            r_expire_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_expired) begin
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!w_any_expired) begin
                        r_state <= ST_IDLE;
                    end else if (w_expired[r_ptr]) begin
                        r_expire_idx   <= r_ptr;
                        r_expire_valid <= 1'b1;
                        r_state        <= ST_PRESENT;
                    end else begin
                        r_ptr <= r_ptr + IDX_W'(1);
                    end
                end
                ST_PRESENT: begin
                    // Report is held stable until accepted, even if it went stale.
                    if (expire_ready) begin
                        r_expire_valid <= 1'b0;
                        r_ptr          <= r_ptr + IDX_W'(1);
                        r_state        <= ST_SCAN;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_expire_valid <= 1'b0;
                end
            endcase
        end
    end

    assign valid_vec     = r_valid;
    assign timer_enabled = |r_valid;
    assign expire_valid  = r_expire_valid;
    assign expire_idx    = r_expire_idx;

`ifdef EXPIRE_COUNT_EN
    logic        w_inv_fire;
    logic [15:0] r_expire_count;

    // Count only handshakes that really removed an entry (not stale reports).
    assign w_inv_fire = |(w_acc_hit & ~w_clr_hit & ~w_tch_hit);

    // Saturating count of expiry-driven invalidations.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_expire_count <= '0;
        end else if (w_inv_fire && (r_expire_count != 16'hFFFF)) begin
            r_expire_count <= r_expire_count + 16'd1;
        end
    end

    assign expire_count = r_expire_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_entry_age_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_entry_age_tracker
//  Purpose  : Self-checking bench for entry_age_tracker: directed vector
//             table, hand-written corner sequences and randomized traffic
//             checked against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_entry_age_tracker;

    localparam int ENTRIES = 8;
    localparam int IDX_W   = 3;
    localparam int AGE_W   = 4;
    localparam int MAX_AGE = 10;

    logic               clk = 1'b0;
    logic               sync_reset;
    logic               second_elapsed;
    logic               timer_enabled;
    logic               touch_valid;
    logic [IDX_W-1:0]   touch_idx;
    logic               clear_valid;
    logic [IDX_W-1:0]   clear_idx;
    logic [ENTRIES-1:0] valid_vec;
    logic               expire_valid;
    logic [IDX_W-1:0]   expire_idx;
    logic               expire_ready;
`ifdef EXPIRE_COUNT_EN
    logic [15:0]        expire_count;
`endif

    always #10 clk = ~clk;

    entry_age_tracker #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .AGE_W   (AGE_W),
        .MAX_AGE (MAX_AGE)
    ) dut (
        .clk            (clk),
        .sync_reset     (sync_reset),
        .second_elapsed (second_elapsed),
        .timer_enabled  (timer_enabled),
        .touch_valid    (touch_valid),
        .touch_idx      (touch_idx),
        .clear_valid    (clear_valid),
        .clear_idx      (clear_idx),
        .valid_vec      (valid_vec),
        .expire_valid   (expire_valid),
        .expire_idx     (expire_idx),
        .expire_ready   (expire_ready)
`ifdef EXPIRE_COUNT_EN
        ,
        .expire_count   (expire_count)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_hs   = 0;   // handshakes observed on the DUT interface

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_age   [ENTRIES];
    bit m_valid [ENTRIES];
    int m_mode;   // 0 idle, 1 scanning, 2 presenting
    int m_ptr;
    bit m_ev;
    int m_eidx;
    int m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_age[i]   = 0;
            m_valid[i] = 0;
        end
        m_mode = 0; m_ptr = 0; m_ev = 0; m_eidx = 0; m_cnt = 0;
    endfunction

    function automatic logic [ENTRIES-1:0] model_vec();
        logic [ENTRIES-1:0] v = '0;
        for (int i = 0; i < ENTRIES; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic void model_edge();
        bit exp_pre [ENTRIES];
        bit any = 0;
        bit hs;
        bit t_hit, c_hit;
        for (int i = 0; i < ENTRIES; i++) begin
            exp_pre[i] = m_valid[i] && (m_age[i] == MAX_AGE);
            any |= exp_pre[i];
        end
        hs = (m_mode == 2) && expire_ready;
        if (hs && exp_pre[m_eidx]
               && !(touch_valid && int'(touch_idx) == m_eidx)
               && !(clear_valid && int'(clear_idx) == m_eidx)
               && m_cnt < 65535)
            m_cnt++;
        for (int i = 0; i < ENTRIES; i++) begin
            t_hit = touch_valid && (int'(touch_idx) == i);
            c_hit = clear_valid && (int'(clear_idx) == i);
            if (c_hit) begin
                m_valid[i] = 0; m_age[i] = 0;
            end else if (t_hit) begin
                m_valid[i] = 1; m_age[i] = 0;
            end else if (hs && m_eidx == i && exp_pre[i]) begin
                m_valid[i] = 0; m_age[i] = 0;
            end else if (second_elapsed && m_valid[i]) begin
                m_age[i] = (m_age[i] + 1 > MAX_AGE) ? MAX_AGE : m_age[i] + 1;
            end
        end
        case (m_mode)
            0: if (any) m_mode = 1;
            1: begin
                if (!any) m_mode = 0;
                else if (exp_pre[m_ptr]) begin
                    m_eidx = m_ptr; m_ev = 1; m_mode = 2;
                end else m_ptr = (m_ptr + 1) % ENTRIES;
            end
            default: if (expire_ready) begin
                m_ev = 0; m_ptr = (m_ptr + 1) % ENTRIES; m_mode = 1;
            end
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    // One clock: drive inputs, advance model at the edge, compare #1 later.
    task automatic step(input bit tv, input int ti, input bit cv, input int ci,
                        input bit tk, input bit rdy, input bit rst);
        touch_valid    = tv;
        touch_idx      = IDX_W'(ti);
        clear_valid    = cv;
        clear_idx      = IDX_W'(ci);
        second_elapsed = tk;
        expire_ready   = rdy;
        sync_reset     = rst;
        if (!rst && rdy && expire_valid) n_hs++;
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
        chk("model.valid_vec", 32'(valid_vec), 32'(model_vec()));
        chk("model.expire_valid", 32'(expire_valid), 32'(m_ev));
        if (m_ev) chk("model.expire_idx", 32'(expire_idx), 32'(m_eidx));
        chk("model.timer_enabled", 32'(timer_enabled), 32'(|model_vec()));
`ifdef EXPIRE_COUNT_EN
        chk("model.expire_count", 32'(expire_count), 32'(m_cnt));
`endif
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, rdy, 0);
    endtask

    task automatic ticks(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1, rdy, 0);
    endtask

    // Idle until a report is presented or the budget runs out.
    task automatic wait_report(input int max, input bit rdy, input string name,
                               input int exp_idx);
        for (int k = 0; k < max && !expire_valid; k++) step(0, 0, 0, 0, 0, rdy, 0);
        chk({name, ".expire_valid"}, 32'(expire_valid), 32'd1);
        chk({name, ".expire_idx"}, 32'(expire_idx), 32'(exp_idx));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int               rep;
        bit               tv;
        int               ti;
        bit               cv;
        int               ci;
        bit               tk;
        bit               rdy;
        logic [ENTRIES-1:0] vec;
        bit               ev;
        int               eidx;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int cnt0;
        touch_valid = 0; touch_idx = '0; clear_valid = 0; clear_idx = '0;
        second_elapsed = 0; expire_ready = 0; sync_reset = 1;
        model_reset();

        // Reset state
        do_reset();
        chk("reset.valid_vec", 32'(valid_vec), 32'h0);
        chk("reset.expire_valid", 32'(expire_valid), 32'h0);
        chk("reset.expire_idx", 32'(expire_idx), 32'h0);
        chk("reset.timer_enabled", 32'(timer_enabled), 32'h0);

        // Table: touch+clear same index, then basic expiry of entry 3 with
        // the exact scan timing from ptr=0.
        tbl[0] = '{1, 1, 2, 1, 2, 0, 0, 8'h00, 0, 0};
        tbl[1] = '{1, 1, 3, 0, 0, 0, 0, 8'h08, 0, 0};
        tbl[2] = '{9, 0, 0, 0, 0, 1, 0, 8'h08, 0, 0};
        tbl[3] = '{1, 0, 0, 0, 0, 1, 0, 8'h08, 0, 0};
        tbl[4] = '{1, 0, 0, 0, 0, 0, 0, 8'h08, 0, 0};
        tbl[5] = '{3, 0, 0, 0, 0, 0, 0, 8'h08, 0, 0};
        tbl[6] = '{1, 0, 0, 0, 0, 0, 0, 8'h08, 1, 3};
        tbl[7] = '{1, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0};
        tbl[8] = '{1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0};
        for (int r = 0; r < 9; r++) begin
            for (int k = 0; k < tbl[r].rep; k++)
                step(tbl[r].tv, tbl[r].ti, tbl[r].cv, tbl[r].ci, tbl[r].tk, tbl[r].rdy, 0);
            chk($sformatf("tbl[%0d].valid_vec", r), 32'(valid_vec), 32'(tbl[r].vec));
            chk($sformatf("tbl[%0d].expire_valid", r), 32'(expire_valid), 32'(tbl[r].ev));
            chk($sformatf("tbl[%0d].timer_enabled", r), 32'(timer_enabled), 32'(|tbl[r].vec));
            if (tbl[r].ev)
                chk($sformatf("tbl[%0d].expire_idx", r), 32'(expire_idx), 32'(tbl[r].eidx));
        end
`ifdef EXPIRE_COUNT_EN
        chk("tbl.expire_count", 32'(expire_count), 32'd1);
`endif

        // Reset in the middle of a presented report, with traffic on the inputs
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        ticks(MAX_AGE, 0);
        wait_report(12, 0, "rst_pre", 0);
        step(1, 5, 0, 0, 1, 1, 1);
        chk("rst1.valid_vec", 32'(valid_vec), 32'h0);
        chk("rst1.expire_valid", 32'(expire_valid), 32'h0);
        chk("rst1.timer_enabled", 32'(timer_enabled), 32'h0);
        step(1, 6, 0, 0, 1, 1, 1);
        chk("rst2.valid_vec", 32'(valid_vec), 32'h0);

        // Basic expiry with ready held high
        do_reset();
        step(1, 3, 0, 0, 0, 1, 0);
        ticks(MAX_AGE, 1);
        wait_report(9, 1, "basic", 3);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("basic.valid3", 32'(valid_vec[3]), 32'd0);
        chk("basic.timer_enabled", 32'(timer_enabled), 32'd0);
`ifdef EXPIRE_COUNT_EN
        chk("basic.expire_count", 32'(expire_count), 32'd1);
`endif

        // Refresh keeps an entry alive
        do_reset();
        hs0 = n_hs;
        step(1, 5, 0, 0, 0, 1, 0);
        ticks(MAX_AGE - 1, 1);
        step(1, 5, 0, 0, 0, 1, 0);
        ticks(MAX_AGE - 1, 1);
        idle(12, 1);
        chk("refresh.no_report", 32'(n_hs - hs0), 32'd0);
        chk("refresh.valid5", 32'(valid_vec[5]), 32'd1);
        ticks(1, 0);
        wait_report(12, 0, "refresh", 5);
        step(0, 0, 0, 0, 0, 1, 0);

        // Ordering and stability under back-pressure
        do_reset();
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 6, 0, 0, 0, 0, 0);
        ticks(MAX_AGE, 0);
        wait_report(12, 0, "order1", 1);
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk("order.hold_idx", 32'(expire_idx), 32'd1);
        end
        step(0, 0, 0, 0, 0, 1, 0);
        wait_report(12, 1, "order2", 6);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("order.valid_vec", 32'(valid_vec), 32'h0);

        // Priority and saturation
        do_reset();
        step(1, 2, 1, 2, 0, 0, 0);
        chk("prio.valid2", 32'(valid_vec[2]), 32'd0);
        hs0 = n_hs;
        step(1, 4, 0, 0, 0, 0, 0);
        ticks(15, 0);
        idle(30, 1);
        chk("sat.one_report", 32'(n_hs - hs0), 32'd1);
        chk("sat.valid_vec", 32'(valid_vec), 32'h0);

        // Stale report: refreshed while presented
        do_reset();
        step(1, 4, 0, 0, 0, 0, 0);
        ticks(MAX_AGE, 0);
        wait_report(12, 0, "stale_pre", 4);
        cnt0 = m_cnt;
        step(1, 4, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("stale.valid4", 32'(valid_vec[4]), 32'd1);
        chk("stale.expire_valid", 32'(expire_valid), 32'd0);
`ifdef EXPIRE_COUNT_EN
        chk("stale.expire_count", 32'(expire_count), 32'(cnt0));
`endif
        hs0 = n_hs;
        idle(20, 1);
        chk("stale.no_rereport", 32'(n_hs - hs0), 32'd0);
        ticks(MAX_AGE - 1, 1);
        chk("stale.still_valid", 32'(valid_vec[4]), 32'd1);
        ticks(1, 1);
        wait_report(12, 1, "stale_re", 4);
        step(0, 0, 0, 0, 0, 1, 0);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 9) < 3, $urandom_range(0, ENTRIES - 1),
                 $urandom_range(0, 9) < 1, $urandom_range(0, ENTRIES - 1),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 299) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
